// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command scheduler: FSM states,
// frame layout, ASCII symbols and default clamp limits.
package servo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CONV = 3'd2,
    ST_SEND = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam int FRAME_LEN   = 15;
  localparam int IDX_HASH    = 0;
  localparam int IDX_ID      = 3;
  localparam int IDX_P       = 4;
  localparam int IDX_PWM     = 5;
  localparam int IDX_T       = 9;
  localparam int IDX_TIME    = 10;
  localparam int IDX_BANG    = FRAME_LEN - 1;

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_T    = 8'h54;
  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam int PWM_MIN_DEF = 500;
  localparam int PWM_MAX_DEF = 2500;
  localparam int TIME_MAX    = 9999;
  localparam int CONV_CYCLES = 14;

endpackage

// File: rtl/dec4_ascii.sv
// Sequential 14-bit double-dabble: start latches the value, 14 cycles later
// done rises and ascii holds four decimal digits, most significant in [31:24].
module dec4_ascii
  import servo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [31:0] ascii
);

  // [29:14] BCD accumulator, [13:0] binary still to be shifted in
  logic [29:0] sr;
  logic [3:0]  cnt;
  logic        valid;

  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int d = 0; d < 4; d++) begin
      if (t[14+4*d +: 4] >= 4'd5) t[14+4*d +: 4] = t[14+4*d +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (start) begin
      sr    <= {16'd0, bin};
      cnt   <= 4'(CONV_CYCLES);
      valid <= 1'b0;
    end else if (cnt != 4'd0) begin
      sr    <= dd_step(sr);
      cnt   <= cnt - 4'd1;
      if (cnt == 4'd1) valid <= 1'b1;
    end
  end

  assign done  = valid;
  assign ascii = {ASCII_ZERO + {4'd0, sr[29:26]},
                  ASCII_ZERO + {4'd0, sr[25:22]},
                  ASCII_ZERO + {4'd0, sr[21:18]},
                  ASCII_ZERO + {4'd0, sr[17:14]}};

endmodule

// File: rtl/servo_cmd_scheduler.sv
// Servo target table with round-robin scheduling; emits "#iiiPppppTtttt!"
// frames on a valid/ready byte stream with an idle gap after each frame.
module servo_cmd_scheduler
  import servo_pkg::*;
#(
  parameter int NUM_SERVO  = 6,
  parameter int PWM_MIN    = PWM_MIN_DEF,
  parameter int PWM_MAX    = PWM_MAX_DEF,
  parameter int GAP_CYCLES = 5000,
  parameter int PWM_RESET  = 1500,
  parameter int TIME_RESET = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [2:0]           wr_id,
  input  logic [11:0]          wr_pwm,
  input  logic [13:0]          wr_time,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [NUM_SERVO-1:0] pending,
  output logic                 frame_done,
  output state_t               dbg_state
);

  // Handshake: a byte transfers on a cycle where tx_valid && tx_ready; while
  // tx_valid is high, tx_data holds and tx_valid stays up until that transfer.

  localparam logic [NUM_SERVO-1:0] ONE = (NUM_SERVO)'(1);

  logic [11:0] pwm_tab  [NUM_SERVO];
  logic [13:0] time_tab [NUM_SERVO];

  state_t      state, state_nxt;
  logic [2:0]  last_id, cur_id, sel_id;
  logic        sel_found;
  logic [3:0]  k, conv_cnt;
  logic [31:0] gap_cnt;

  logic        wr_ok, conv_start, hs;
  logic [11:0] pwm_clamped;
  logic [13:0] time_clamped;
  logic [NUM_SERVO-1:0] set_mask, clr_mask;

  logic        pwm_done, time_done;
  logic [31:0] pwm_ascii, time_ascii;

  assign wr_ok = wr_en && ({1'b0, wr_id} < 4'(NUM_SERVO));

  always_comb begin
    pwm_clamped = wr_pwm;
    if (wr_pwm < 12'(PWM_MIN))      pwm_clamped = 12'(PWM_MIN);
    else if (wr_pwm > 12'(PWM_MAX)) pwm_clamped = 12'(PWM_MAX);
    time_clamped = (wr_time > 14'(TIME_MAX)) ? 14'(TIME_MAX) : wr_time;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SERVO; i++) begin
        pwm_tab[i]  <= 12'(PWM_RESET);
        time_tab[i] <= 14'(TIME_RESET);
      end
    end else if (wr_ok) begin
      pwm_tab[wr_id]  <= pwm_clamped;
      time_tab[wr_id] <= time_clamped;
    end
  end

  // A write in the same cycle as the LOAD clear re-arms the entry.
  assign set_mask = wr_ok ? (ONE << wr_id) : '0;
  assign clr_mask = (state == ST_LOAD) ? (ONE << cur_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  always_comb begin
    logic [3:0] j;
    sel_id    = '0;
    sel_found = 1'b0;
    j         = '0;
    for (int i = 1; i <= NUM_SERVO; i++) begin
      j = {1'b0, last_id} + 4'(i);
      if (j >= 4'(NUM_SERVO)) j = j - 4'(NUM_SERVO);
      if (!sel_found && pending[j[2:0]]) begin
        sel_found = 1'b1;
        sel_id    = j[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (sel_found) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CONV;
      ST_CONV: if (conv_cnt == 4'(CONV_CYCLES - 1)) state_nxt = ST_SEND;
      ST_SEND: if (hs && k == 4'(IDX_BANG)) state_nxt = ST_GAP;
      ST_GAP:  if (gap_cnt == 32'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id   <= '0;
      last_id  <= 3'(NUM_SERVO - 1);
      k        <= '0;
      conv_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (sel_found) cur_id <= sel_id;
        ST_LOAD: begin
          last_id  <= cur_id;
          conv_cnt <= '0;
        end
        ST_CONV: conv_cnt <= conv_cnt + 4'd1;
        ST_SEND: if (hs) begin
          if (k == 4'(IDX_BANG)) begin
            k       <= '0;
            gap_cnt <= '0;
          end else begin
            k <= k + 4'd1;
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  // The converters latch the table entry at LOAD and act as the frame registers.
  assign conv_start = (state == ST_LOAD);

  dec4_ascii u_pwm_dec (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   ({2'b00, pwm_tab[cur_id]}),
    .done  (pwm_done),
    .ascii (pwm_ascii)
  );

  dec4_ascii u_time_dec (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (time_tab[cur_id]),
    .done  (time_done),
    .ascii (time_ascii)
  );

  assign tx_valid   = (state == ST_SEND) && pwm_done && time_done;
  assign hs         = tx_valid && tx_ready;
  assign frame_done = hs && (k == 4'(IDX_BANG));
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

  always_comb begin
    tx_data = 8'h00;
    if (tx_valid) begin
      case (k)
        4'd0:    tx_data = ASCII_HASH;
        4'd1:    tx_data = ASCII_ZERO;
        4'd2:    tx_data = ASCII_ZERO;
        4'd3:    tx_data = ASCII_ZERO + {5'd0, cur_id};
        4'd4:    tx_data = ASCII_P;
        4'd5:    tx_data = pwm_ascii[31:24];
        4'd6:    tx_data = pwm_ascii[23:16];
        4'd7:    tx_data = pwm_ascii[15:8];
        4'd8:    tx_data = pwm_ascii[7:0];
        4'd9:    tx_data = ASCII_T;
        4'd10:   tx_data = time_ascii[31:24];
        4'd11:   tx_data = time_ascii[23:16];
        4'd12:   tx_data = time_ascii[15:8];
        4'd13:   tx_data = time_ascii[7:0];
        4'd14:   tx_data = ASCII_BANG;
        default: tx_data = 8'h00;
      endcase
    end
  end

endmodule
